// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage and its neighbours (Decode, hazard unit, imem).
// master = fetch stage; slave = the surrounding pipeline and instruction memory.
interface fetch_if #(parameter int ADDR_BITS = 10) ();
  logic                 stall;
  logic                 flush;
  logic                 redirect;
  logic [31:0]          redirectTarget;
  logic                 halt;
  logic [ADDR_BITS-1:0] imemAddr;
  logic [31:0]          imemData;
  logic [31:0]          instrD;
  logic [31:0]          pcD;
  logic                 bubbleD;
  logic [31:0]          pcF;
  logic                 halted;
  logic                 fault;
  logic [31:0]          fetchCount;
  logic [1:0]           state;

  // Control inputs are level signals sampled on each rising edge; there is
  // no valid/ready pair: stall is the only back-pressure and holds everything.
  modport master (
    input  stall, flush, redirect, redirectTarget, halt, imemData,
    output imemAddr, instrD, pcD, bubbleD, pcF, halted, fault, fetchCount, state
  );
  modport slave (
    output stall, flush, redirect, redirectTarget, halt, imemData,
    input  imemAddr, instrD, pcD, bubbleD, pcF, halted, fault, fetchCount, state
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage with IF/ID register, delay-slot redirects,
// syscall halt and illegal-redirect fault. State is exported on bus.state.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          IMEM_WORDS = 1024,
  parameter int          ADDR_BITS  = 10
) (
  input logic      clk,
  input logic      reset,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {RUN = 2'd0, HALTED = 2'd1, FAULT = 2'd2} state_t;

  localparam logic [32:0] MEM_END = {1'b0, RESET_PC} + 33'(4 * IMEM_WORDS);

  state_t      state, state_next;
  logic [31:0] pc_f, pc_f_next;
  logic [31:0] instr_d, instr_d_next;
  logic [31:0] pc_d, pc_d_next;
  logic        bubble_d, bubble_d_next;
  logic [31:0] count, count_next;
  logic        halted, halted_next;
  logic        fault, fault_next;
  logic [31:0] pc_offset;
  logic        bad_target;

  assign pc_offset  = pc_f - RESET_PC;
  assign bad_target = (bus.redirectTarget[1:0] != 2'b00)
                   || (bus.redirectTarget < RESET_PC)
                   || ({1'b0, bus.redirectTarget} >= MEM_END);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= RUN;
      pc_f     <= RESET_PC;
      instr_d  <= 32'h0;
      pc_d     <= RESET_PC;
      bubble_d <= 1'b1;
      count    <= 32'h0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_next;
      pc_f     <= pc_f_next;
      instr_d  <= instr_d_next;
      pc_d     <= pc_d_next;
      bubble_d <= bubble_d_next;
      count    <= count_next;
      halted   <= halted_next;
      fault    <= fault_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_f_next     = pc_f;
    instr_d_next  = instr_d;
    pc_d_next     = pc_d;
    bubble_d_next = bubble_d;
    count_next    = count;
    halted_next   = halted;
    fault_next    = fault;
    case (state)
      RUN: begin
        if (bus.stall) begin
          // flush still injects a bubble while the PC is frozen
          if (bus.flush) begin
            instr_d_next  = 32'h0;
            bubble_d_next = 1'b1;
          end
        end else if (bus.halt) begin
          instr_d_next  = 32'h0;
          bubble_d_next = 1'b1;
          halted_next   = 1'b1;
          state_next    = HALTED;
        end else if (bus.redirect && bad_target) begin
          // delay slot still delivered; PC freezes on the faulting fetch
          instr_d_next  = bus.imemData;
          pc_d_next     = pc_f;
          bubble_d_next = 1'b0;
          count_next    = count + 32'd1;
          fault_next    = 1'b1;
          state_next    = FAULT;
        end else begin
          pc_f_next = bus.redirect ? bus.redirectTarget : pc_f + 32'd4;
          if (bus.flush) begin
            instr_d_next  = 32'h0;
            bubble_d_next = 1'b1;
          end else begin
            instr_d_next  = bus.imemData;
            pc_d_next     = pc_f;
            bubble_d_next = 1'b0;
            count_next    = count + 32'd1;
          end
        end
      end
      default: begin
        instr_d_next  = 32'h0;
        bubble_d_next = 1'b1;
      end
    endcase
  end

  assign bus.imemAddr   = ADDR_BITS'(pc_offset >> 2);
  assign bus.instrD     = instr_d;
  assign bus.pcD        = pc_d;
  assign bus.bubbleD    = bubble_d;
  assign bus.pcF        = pc_f;
  assign bus.halted     = halted;
  assign bus.fault      = fault;
  assign bus.fetchCount = count;
  assign bus.state      = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, delay slot,
// halt, illegal redirects, memory-edge redirects and flush.
module tb_fetch_stage;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] imem [0:1023];
  logic [31:0] bad_list [4];

  fetch_if #(.ADDR_BITS(10)) bus ();

  fetch_stage #(.RESET_PC(32'h0000_3000), .IMEM_WORDS(1024), .ADDR_BITS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.imemData = imem[bus.imemAddr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect = 1'b0;
    bus.redirectTarget = 32'h0; bus.halt = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.pcF !== 32'h3000) begin failures++; $display("FAIL reset_pcF got=%h exp=%h", bus.pcF, 32'h3000); end
    checks++; if (bus.instrD !== 32'h0) begin failures++; $display("FAIL reset_instrD got=%h exp=%h", bus.instrD, 32'h0); end
    checks++; if (bus.pcD !== 32'h3000) begin failures++; $display("FAIL reset_pcD got=%h exp=%h", bus.pcD, 32'h3000); end
    checks++; if (bus.bubbleD !== 1'b1) begin failures++; $display("FAIL reset_bubbleD got=%b exp=1", bus.bubbleD); end
    checks++; if (bus.halted !== 1'b0 || bus.fault !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", bus.halted, bus.fault); end
    checks++; if (bus.fetchCount !== 32'h0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.fetchCount); end
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.imemAddr !== 10'd0) begin failures++; $display("FAIL reset_imemAddr got=%0d exp=0", bus.imemAddr); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_instr [3];
    logic [31:0] exp_pc [3];
    exp_instr[0] = 32'hC0DE_0000; exp_instr[1] = 32'hC0DE_0001; exp_instr[2] = 32'hC0DE_0002;
    exp_pc[0] = 32'h3000; exp_pc[1] = 32'h3004; exp_pc[2] = 32'h3008;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.instrD !== exp_instr[i] || bus.pcD !== exp_pc[i] || bus.bubbleD !== 1'b0)
        begin failures++; $display("FAIL seq_load%0d got=%h/%h/%b exp=%h/%h/0", i, bus.instrD, bus.pcD, bus.bubbleD, exp_instr[i], exp_pc[i]); end
      checks++; if (bus.fetchCount !== 32'(i + 1)) begin failures++; $display("FAIL seq_count%0d got=%0d exp=%0d", i, bus.fetchCount, i + 1); end
    end
    checks++; if (bus.pcF !== 32'h300C || bus.imemAddr !== 10'd3) begin failures++; $display("FAIL seq_pcF got=%h/%0d exp=300c/3", bus.pcF, bus.imemAddr); end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    bus.stall = 1'b1;
    bus.redirect = 1'b1; bus.redirectTarget = 32'h3080;
    bus.halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.pcF !== 32'h3008 || bus.instrD !== 32'hC0DE_0001 || bus.pcD !== 32'h3004 || bus.fetchCount !== 32'd2 || bus.bubbleD !== 1'b0 || bus.halted !== 1'b0)
        begin failures++; $display("FAIL stall_hold%0d got=%h/%h/%h/%0d/%b/%b exp=3008/c0de0001/3004/2/0/0", i, bus.pcF, bus.instrD, bus.pcD, bus.fetchCount, bus.bubbleD, bus.halted); end
    end
    idle_inputs();
    step();
    checks++; if (bus.instrD !== 32'hC0DE_0002 || bus.pcD !== 32'h3008 || bus.pcF !== 32'h300C || bus.fetchCount !== 32'd3)
      begin failures++; $display("FAIL stall_release got=%h/%h/%h/%0d exp=c0de0002/3008/300c/3", bus.instrD, bus.pcD, bus.pcF, bus.fetchCount); end
  endtask

  task automatic test_delay_slot();
    do_reset();
    step(); step();
    bus.redirect = 1'b1; bus.redirectTarget = 32'h3040;
    step();
    idle_inputs();
    checks++; if (bus.pcD !== 32'h3008 || bus.instrD !== 32'hC0DE_0002 || bus.bubbleD !== 1'b0 || bus.pcF !== 32'h3040)
      begin failures++; $display("FAIL dslot_slot got=%h/%h/%b/%h exp=3008/c0de0002/0/3040", bus.pcD, bus.instrD, bus.bubbleD, bus.pcF); end
    step();
    checks++; if (bus.pcD !== 32'h3040 || bus.instrD !== 32'hC0DE_0010 || bus.pcF !== 32'h3044 || bus.fetchCount !== 32'd4)
      begin failures++; $display("FAIL dslot_target got=%h/%h/%h/%0d exp=3040/c0de0010/3044/4", bus.pcD, bus.instrD, bus.pcF, bus.fetchCount); end
  endtask

  task automatic test_halt();
    do_reset();
    step(); step(); step();
    bus.halt = 1'b1; bus.redirect = 1'b1; bus.redirectTarget = 32'h3040; bus.flush = 1'b1;
    step();
    idle_inputs();
    checks++; if (bus.bubbleD !== 1'b1 || bus.instrD !== 32'h0 || bus.halted !== 1'b1 || bus.pcF !== 32'h300C || bus.fetchCount !== 32'd3 || bus.state !== 2'd1)
      begin failures++; $display("FAIL halt_enter got=%b/%h/%b/%h/%0d/%0d exp=1/0/1/300c/3/1", bus.bubbleD, bus.instrD, bus.halted, bus.pcF, bus.fetchCount, bus.state); end
    bus.redirect = 1'b1; bus.redirectTarget = 32'h3040; bus.flush = 1'b1;
    step(); step();
    checks++; if (bus.bubbleD !== 1'b1 || bus.halted !== 1'b1 || bus.pcF !== 32'h300C || bus.fetchCount !== 32'd3 || bus.fault !== 1'b0)
      begin failures++; $display("FAIL halt_absorb got=%b/%b/%h/%0d/%b exp=1/1/300c/3/0", bus.bubbleD, bus.halted, bus.pcF, bus.fetchCount, bus.fault); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    idle_inputs();
    checks++; if (bus.pcF !== 32'h3000 || bus.halted !== 1'b0 || bus.state !== 2'd0 || bus.bubbleD !== 1'b1)
      begin failures++; $display("FAIL halt_reset got=%h/%b/%0d/%b exp=3000/0/0/1", bus.pcF, bus.halted, bus.state, bus.bubbleD); end
  endtask

  task automatic test_illegal_redirect();
    bad_list[0] = 32'h3042; bad_list[1] = 32'h7000; bad_list[2] = 32'h4000; bad_list[3] = 32'h2FFC;
    for (int k = 0; k < 4; k++) begin
      do_reset();
      step(); step();
      bus.redirect = 1'b1; bus.redirectTarget = bad_list[k];
      step();
      idle_inputs();
      checks++; if (bus.fault !== 1'b1 || bus.pcD !== 32'h3008 || bus.instrD !== 32'hC0DE_0002 || bus.bubbleD !== 1'b0 || bus.pcF !== 32'h3008 || bus.fetchCount !== 32'd3)
        begin failures++; $display("FAIL illegal_%h_slot got=%b/%h/%h/%b/%h/%0d exp=1/3008/c0de0002/0/3008/3", bad_list[k], bus.fault, bus.pcD, bus.instrD, bus.bubbleD, bus.pcF, bus.fetchCount); end
      bus.redirect = 1'b1; bus.redirectTarget = 32'h3040;
      step(); step();
      checks++; if (bus.bubbleD !== 1'b1 || bus.instrD !== 32'h0 || bus.pcF !== 32'h3008 || bus.fetchCount !== 32'd3 || bus.state !== 2'd2 || bus.halted !== 1'b0)
        begin failures++; $display("FAIL illegal_%h_after got=%b/%h/%h/%0d/%0d/%b exp=1/0/3008/3/2/0", bad_list[k], bus.bubbleD, bus.instrD, bus.pcF, bus.fetchCount, bus.state, bus.halted); end
      idle_inputs();
    end
  endtask

  task automatic test_mem_edge();
    do_reset();
    step();
    bus.redirect = 1'b1; bus.redirectTarget = 32'h3FFC;
    step();
    idle_inputs();
    checks++; if (bus.fault !== 1'b0 || bus.pcF !== 32'h3FFC || bus.imemAddr !== 10'd1023)
      begin failures++; $display("FAIL edge_last got=%b/%h/%0d exp=0/3ffc/1023", bus.fault, bus.pcF, bus.imemAddr); end
    step();
    checks++; if (bus.instrD !== 32'hC0DE_03FF || bus.pcF !== 32'h4000 || bus.imemAddr !== 10'd0)
      begin failures++; $display("FAIL edge_wrap got=%h/%h/%0d exp=c0de03ff/4000/0", bus.instrD, bus.pcF, bus.imemAddr); end
  endtask

  task automatic test_flush();
    do_reset();
    step(); step();
    bus.stall = 1'b1; bus.flush = 1'b1;
    step();
    checks++; if (bus.bubbleD !== 1'b1 || bus.instrD !== 32'h0 || bus.pcF !== 32'h3008 || bus.fetchCount !== 32'd2)
      begin failures++; $display("FAIL flush_stall got=%b/%h/%h/%0d exp=1/0/3008/2", bus.bubbleD, bus.instrD, bus.pcF, bus.fetchCount); end
    bus.stall = 1'b0;
    step();
    checks++; if (bus.bubbleD !== 1'b1 || bus.instrD !== 32'h0 || bus.pcF !== 32'h300C || bus.fetchCount !== 32'd2)
      begin failures++; $display("FAIL flush_only got=%b/%h/%h/%0d exp=1/0/300c/2", bus.bubbleD, bus.instrD, bus.pcF, bus.fetchCount); end
    idle_inputs();
    step();
    checks++; if (bus.bubbleD !== 1'b0 || bus.instrD !== 32'hC0DE_0003 || bus.pcD !== 32'h300C || bus.fetchCount !== 32'd3)
      begin failures++; $display("FAIL flush_resume got=%b/%h/%h/%0d exp=0/c0de0003/300c/3", bus.bubbleD, bus.instrD, bus.pcD, bus.fetchCount); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 1024; i++) imem[i] = {16'hC0DE, 16'(i)};
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_delay_slot();
    test_halt();
    test_illegal_redirect();
    test_mem_edge();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
